ife_block_dispatch_queue: RTL and testbench

IFE_BLOCK_DISPATCH_QUEUE -- requirements
Module: ife_block_dispatch_queue

---
 rtl/ife_pkg.sv | 20 ++
 rtl/ife_rr_arbiter.sv | 37 +++
 rtl/ife_block_dispatch_queue.sv | 129 ++++++++++++
 tb/tb_ife_block_dispatch_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ife_pkg.sv
// Shared defaults for the block dispatch queue: parameter values, the default
// block record and a small modulo-increment helper.
package ife_pkg;

    localparam int unsigned DefBlockIdWidth = 8;
    localparam int unsigned DefInstrWidth   = 32;
    localparam int unsigned DefBlockSize    = 4;
    localparam int unsigned DefQueueDepth   = 8;
    localparam int unsigned DefNumCores     = 2;

    typedef struct packed {
        logic [DefBlockIdWidth-1:0]                   id;
        logic [DefBlockSize-1:0][DefInstrWidth-1:0]   instrs;
    } block_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/ife_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr_i (mod NUM_REQ)
// wins; returns a one-hot grant plus its index.
module ife_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned IDX_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [IDX_WIDTH-1:0] grant_idx_o
);

    logic                 found;
    logic [IDX_WIDTH:0]   sum;
    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_i} + (IDX_WIDTH + 1)'(i);
            if (sum >= (IDX_WIDTH + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_WIDTH + 1)'(NUM_REQ);
            end
            cand = sum[IDX_WIDTH-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/ife_block_dispatch_queue.sv
// Block FIFO feeding one registered output slot per core; the head entry moves
// into one available slot per cycle, chosen round-robin.
module ife_block_dispatch_queue
    import ife_pkg::*;
#(
    parameter int unsigned BLOCK_ID_WIDTH = DefBlockIdWidth,
    parameter int unsigned INSTR_WIDTH    = DefInstrWidth,
    parameter int unsigned BLOCK_SIZE     = DefBlockSize,
    parameter int unsigned QUEUE_DEPTH    = DefQueueDepth,
    parameter int unsigned NUM_CORES      = DefNumCores
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [BLOCK_ID_WIDTH-1:0]                   block_id_in,
    input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0]           block_in,
    input  logic                                        valid_in,
    output logic                                        ready_in,
    input  logic                                        flush_i,
    output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0]         core_block_id_out,
    output logic [NUM_CORES*BLOCK_SIZE*INSTR_WIDTH-1:0] core_block_out,
    output logic [NUM_CORES-1:0]                        core_valid_out,
    input  logic [NUM_CORES-1:0]                        core_ready,
    output logic [$clog2(QUEUE_DEPTH):0]                count_o
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned RrW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned BlkW = BLOCK_SIZE * INSTR_WIDTH;

    typedef struct packed {
        logic [BLOCK_ID_WIDTH-1:0]                id;
        logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0]   instrs;
    } block_t;

    logic [PtrW:0]        head_q, head_d, tail_q, tail_d;
    logic [NUM_CORES-1:0] slot_valid_q, slot_valid_d;
    logic [RrW-1:0]       rr_q, rr_d;

    block_t mem_q  [QUEUE_DEPTH];
    block_t slot_q [NUM_CORES];

    logic                 full, empty, push, dispatch;
    logic [NUM_CORES-1:0] slot_avail, req, grant;
    logic [RrW-1:0]       grant_idx;
    block_t               in_blk, head_blk;

    // Wrap bit set apart with equal index bits means the FIFO has lapped the head.
    assign full  = (head_q[PtrW-1:0] == tail_q[PtrW-1:0]) && (head_q[PtrW] != tail_q[PtrW]);
    assign empty = (head_q == tail_q);

    assign ready_in = !full && !flush_i;
    assign push     = valid_in && ready_in;

    assign slot_avail = ~slot_valid_q | core_ready;
    assign req        = (empty || flush_i) ? '0 : slot_avail;
    assign dispatch   = |grant;

    assign in_blk.id     = block_id_in;
    assign in_blk.instrs = block_in;
    assign head_blk      = mem_q[head_q[PtrW-1:0]];

    ife_rr_arbiter #(
        .NUM_REQ   (NUM_CORES),
        .IDX_WIDTH (RrW)
    ) u_rr_arbiter (
        .req_i       (req),
        .ptr_i       (rr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        slot_valid_d = slot_valid_q;
        rr_d         = rr_q;
        if (flush_i) begin
            head_d       = '0;
            tail_d       = '0;
            slot_valid_d = '0;
            rr_d         = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + {{PtrW{1'b0}}, 1'b1};
            end
            if (dispatch) begin
                head_d = head_q + {{PtrW{1'b0}}, 1'b1};
                rr_d   = RrW'(wrap_inc(32'(grant_idx), NUM_CORES));
            end
            // Consumed slots drop unless refilled this same cycle.
            slot_valid_d = (slot_valid_q & ~core_ready) | grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            slot_valid_q <= '0;
            rr_q         <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            slot_valid_q <= slot_valid_d;
            rr_q         <= rr_d;
        end
    end

    // Payload storage carries no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q[PtrW-1:0]] <= in_blk;
        end
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (grant[k]) begin
                slot_q[k] <= head_blk;
            end
        end
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_out
        assign core_block_id_out[k*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH] = slot_q[k].id;
        assign core_block_out[k*BlkW +: BlkW]                        = slot_q[k].instrs;
    end

    assign core_valid_out = slot_valid_q;
    assign count_o        = tail_q - head_q;

endmodule

// File: tb/tb_ife_block_dispatch_queue.sv
// Directed bench for ife_block_dispatch_queue: stimulus queues expected blocks,
// a negedge monitor checks every dispatch into a core slot against that queue.
module tb_ife_block_dispatch_queue;

    localparam int IDW = 8;
    localparam int IW  = 32;
    localparam int BS  = 4;
    localparam int QD  = 8;
    localparam int NC  = 2;
    localparam int BW  = BS * IW;
    localparam int CW  = $clog2(QD) + 1;

    logic              clk;
    logic              rst_n;
    logic [IDW-1:0]    block_id_in;
    logic [BW-1:0]     block_in;
    logic              valid_in;
    logic              ready_in;
    logic              flush_i;
    logic [NC*IDW-1:0] core_block_id_out;
    logic [NC*BW-1:0]  core_block_out;
    logic [NC-1:0]     core_valid_out;
    logic [NC-1:0]     core_ready;
    logic [CW-1:0]     count_o;

    ife_block_dispatch_queue #(
        .BLOCK_ID_WIDTH (IDW),
        .INSTR_WIDTH    (IW),
        .BLOCK_SIZE     (BS),
        .QUEUE_DEPTH    (QD),
        .NUM_CORES      (NC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .block_id_in       (block_id_in),
        .block_in          (block_in),
        .valid_in          (valid_in),
        .ready_in          (ready_in),
        .flush_i           (flush_i),
        .core_block_id_out (core_block_id_out),
        .core_block_out    (core_block_out),
        .core_valid_out    (core_valid_out),
        .core_ready        (core_ready),
        .count_o           (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tag;
        int         core;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    function automatic logic [BW-1:0] make_blk(input logic [7:0] tag);
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*IW +: IW] = {tag, 8'(i), ~tag, 8'hA5};
        return b;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a slot got a new block if it is valid now and was free or consumed.
    logic [NC-1:0] pv, pr;
    always @(negedge clk) begin
        int   n;
        exp_t e;
        n = 0;
        if (rst_n) begin
            for (int k = 0; k < NC; k++) begin
                if (core_valid_out[k] && (!pv[k] || pr[k])) begin
                    n++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dispatch core=%0d actual=%0h required=none",
                                 k, core_block_id_out[k*IDW +: IDW]);
                    end else begin
                        e = sb.pop_front();
                        chk("dispatch_tag", BW'(core_block_id_out[k*IDW +: IDW]), BW'(e.tag));
                        chk("dispatch_data", core_block_out[k*BW +: BW], make_blk(e.tag));
                        if (e.core >= 0) chk("dispatch_core", BW'(k), BW'(e.core));
                    end
                end
            end
            if (n > 0) chk("one_dispatch_per_cycle", BW'(n), BW'(1));
        end
        pv = core_valid_out;
        pr = core_ready;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] tag, input int core, output int waited);
        bit done;
        bit r;
        done   = 0;
        waited = 0;
        valid_in    = 1'b1;
        block_id_in = tag;
        block_in    = make_blk(tag);
        while (!done && waited < 200) begin
            @(negedge clk);
            r = ready_in;
            @(posedge clk);
            if (r) begin
                done = 1;
                sb.push_back('{tag, core});
            end else begin
                waited++;
            end
            #1;
        end
        valid_in = 1'b0;
        if (!done) chk("push_timeout", BW'(waited), BW'(0));
    endtask

    task automatic wait_idle(input string name);
        int i;
        core_ready = '1;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (count_o == 0 && core_valid_out == 0) break;
        end
        chk({name, "_drain_timeout"}, BW'(i >= 300), BW'(0));
        chk({name, "_all_delivered"}, BW'(sb.size()), BW'(0));
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        flush_i  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  w;
        bit  stop;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        valid_in    = 1'b0;
        flush_i     = 1'b0;
        core_ready  = '0;
        block_id_in = '0;
        block_in    = '0;

        #12;
        chk("reset_count", BW'(count_o), BW'(0));
        chk("reset_valid", BW'(core_valid_out), BW'(0));
        chk("reset_ready", BW'(ready_in), BW'(1));
        flush_i = 1'b1;
        #1 chk("reset_ready_flush", BW'(ready_in), BW'(0));
        flush_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill with cores stalled.
        core_ready = '0;
        for (int t = 0; t < 8; t++) push(8'(t), (t < 2) ? t : -1, w);
        chk("fill_count_6", BW'(count_o), BW'(6));
        chk("fill_slots", BW'(core_valid_out), BW'(2'b11));
        chk("fill_ready_1", BW'(ready_in), BW'(1));
        push(8'h08, -1, w);
        push(8'h09, -1, w);
        chk("fill_count_8", BW'(count_o), BW'(8));
        chk("fill_ready_0", BW'(ready_in), BW'(0));
        valid_in    = 1'b1;
        block_id_in = 8'h0A;
        block_in    = make_blk(8'h0A);
        repeat (3) begin
            @(negedge clk);
            chk("ninth_ready", BW'(ready_in), BW'(0));
            tick();
        end
        chk("ninth_count", BW'(count_o), BW'(8));
        valid_in = 1'b0;
        wait_idle("fill");

        // Ordering and latency.
        do_reset();
        core_ready = 2'b11;
        push(8'h10, 0, w);
        chk("lat_after_write", BW'(core_valid_out), BW'(0));
        push(8'h11, 1, w);
        chk("lat_after_dispatch", BW'(core_valid_out), BW'(2'b01));
        push(8'h12, 0, w);
        push(8'h13, 1, w);
        wait_idle("order");

        // Core 0 stalled.
        do_reset();
        core_ready = 2'b10;
        push(8'h20, 0, w);
        for (int t = 1; t < 6; t++) push(8'(8'h20 + t), 1, w);
        for (int i = 0; i < 50 && count_o != 0; i++) tick();
        chk("stall_drained", BW'(count_o), BW'(0));
        repeat (3) begin
            tick();
            chk("stall_core0_valid", BW'(core_valid_out[0]), BW'(1));
            chk("stall_core0_tag", BW'(core_block_id_out[IDW-1:0]), BW'(8'h20));
        end
        wait_idle("stall");

        // Wrap-around with random consumer readiness.
        stop = 0;
        fork
            begin
                for (int t = 0; t < 3 * QD + 3; t++) push(8'(8'h30 + t), -1, w);
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1 core_ready = 2'($urandom_range(0, 3));
                end
            end
        join
        wait_idle("wrap");

        // Flush with five queued and both slots occupied.
        do_reset();
        core_ready = '0;
        for (int t = 0; t < 7; t++) push(8'(8'h40 + t), (t < 2) ? t : -1, w);
        chk("pre_flush_count", BW'(count_o), BW'(5));
        chk("pre_flush_slots", BW'(core_valid_out), BW'(2'b11));
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_ready", BW'(ready_in), BW'(0));
        tick();
        flush_i = 1'b0;
        sb.delete();
        chk("flush_count", BW'(count_o), BW'(0));
        chk("flush_slots", BW'(core_valid_out), BW'(0));
        core_ready = 2'b11;
        push(8'h47, 0, w);
        chk("post_flush_accept", BW'(w), BW'(0));
        wait_idle("flush");

        // Asynchronous reset mid-stream.
        do_reset();
        core_ready = '0;
        for (int t = 0; t < 6; t++) push(8'(8'h50 + t), (t < 2) ? t : -1, w);
        chk("pre_rst_count", BW'(count_o), BW'(4));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", BW'(count_o), BW'(0));
        chk("async_rst_slots", BW'(core_valid_out), BW'(0));
        chk("async_rst_ready", BW'(ready_in), BW'(1));
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        core_ready = 2'b11;
        push(8'h60, 0, w);
        wait_idle("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
